// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative HI/LO multiply/divide unit for the EX stage
// Ports: clk/rst_n clock and async active-low reset; start/op/src_a/src_b issue a HI/LO op
// (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO); flush aborts; busy stalls the pipe;
// done pulses after a MULT/DIV write; hi/lo are the architectural registers.
// Define MULDIV_FAST_MULT_EN for a single-cycle array multiply; divide stays iterative.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mul_step, div_step, step, prod;
  logic [WIDTH-1:0] dvs, a_mag, b_mag, quo, rem, hi_res, lo_res;
  logic [WIDTH:0] trial;
  logic is_div, neg_res, neg_rem, issue, md, sgn, last, fin;
  assign busy = state == RUN;
  assign issue = start & ~flush & (state == IDLE);
  assign md = ~op[2];
  // a zero divisor is run unsigned so the natural result is all-ones / original dividend
  assign sgn = ~op[0] & (~op[1] | (|src_b));
  assign a_mag = sgn & src_a[WIDTH-1] ? -src_a : src_a;
  assign b_mag = sgn & src_b[WIDTH-1] ? -src_b : src_b;
  // restoring step on {remainder, dividend}: shift in the next dividend bit, trial subtract
  assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
  assign div_step = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`ifdef MULDIV_FAST_MULT_EN
  assign mul_step = {{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, dvs};
  assign last = ~is_div | (cnt == LAST);
`else
  logic [WIDTH:0] sum;
  // shift-add on {partial product, multiplier}: LSB of multiplier selects the add
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
  assign mul_step = {sum, acc[WIDTH-1:1]};
  assign last = cnt == LAST;
`endif
  assign step = is_div ? div_step : mul_step;
  assign quo = step[WIDTH-1:0];
  assign rem = step[2*WIDTH-1:WIDTH];
  assign prod = neg_res ? -step : step;
  assign hi_res = is_div ? (neg_rem ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
  assign lo_res = is_div ? (neg_res ? -quo : quo) : prod[WIDTH-1:0];
  assign fin = (state == RUN) & ~flush & last;
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = issue & md ? RUN : IDLE;
    else state_nxt = flush | last ? IDLE : RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      dvs <= '0;
      is_div <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nxt;
      done <= fin;
      if (issue & md) begin
        acc <= {{WIDTH{1'b0}}, a_mag};
        dvs <= b_mag;
        is_div <= op[1];
        neg_res <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        neg_rem <= sgn & src_a[WIDTH-1];
        cnt <= '0;
      end else if (state == RUN) begin
        acc <= step;
        cnt <= cnt + CW'(1);
      end
      if (issue & (op == 3'd4)) hi <= src_a;
      if (issue & (op == 3'd5)) lo <= src_a;
      if (fin) begin
        hi <= hi_res;
        lo <= lo_res;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv
module tb_ex_muldiv;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, start = 0, flush = 0;
  logic [2:0] op = 0;
  logic [W-1:0] src_a = 0, src_b = 0;
  logic busy, done;
  logic [W-1:0] hi, lo;
  int n_tests = 0, n_fail = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    longint p;
    sa = a;
    sb = b;
    if (o == 3'd0) begin
      p = longint'(sa) * longint'(sb);
      return p;
    end
    if (o == 3'd1) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == 3'd2) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = sa / sb;
      r = sa % sb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
    int k, lat;
    logic b1;
    logic [63:0] e;
    op = o; src_a = a; src_b = b; start = 1;
    exp_q.push_back(model(o, a, b));
    lat = W;
`ifdef MULDIV_FAST_MULT_EN
    if (!o[1]) lat = 1;
`endif
    k = 0;
    b1 = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) b1 = busy;
      if (k >= hold) start = 0;
    end while (!done && k < 200);
    check("busy_run", b1, 1);
    check("latency", k - 1, lat);
    check("busy_done", busy, 0);
    e = exp_q.pop_front();
    check("hi", hi, e[63:32]);
    check("lo", lo, e[31:0]);
  endtask

  initial begin
    #2;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op(3'd0, 32'hFFFF_FFF9, 32'd3, 1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(3'd3, 32'd100, 32'd0, 1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 1);
    run_op(3'd2, 32'hFFFF_FF9C, 32'd9, 6);
    @(negedge clk);
    op = 3'd4; src_a = 32'h1234; start = 1;
    @(negedge clk);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    check("mthi_hi", hi, 32'h1234);
    op = 3'd5; src_a = 32'h5678;
    @(negedge clk);
    start = 0;
    check("mtlo_busy", busy, 0);
    check("mtlo_hi", hi, 32'h1234);
    check("mtlo_lo", lo, 32'h5678);
    op = 3'd6; src_a = 32'hDEAD; start = 1;
    @(negedge clk);
    start = 0;
    check("op6_busy", busy, 0);
    check("op6_hi", hi, 32'h1234);
    check("op6_lo", lo, 32'h5678);
    op = 3'd3; src_a = 32'd50; src_b = 32'd7; start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    @(negedge clk);
    check("flush_done2", done, 0);
    check("flush_hi", hi, 32'h1234);
    check("flush_lo", lo, 32'h5678);
    run_op(3'd3, 32'd50, 32'd7, 1);
    op = 3'd0; src_a = 32'd123; src_b = 32'd456; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_op(3'd0, 32'd123, 32'hFFFF_FE38, 1);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 5 == 0) ? 32'd0 : (i % 3 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op(3'($urandom_range(0, 3)), a, b, 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
